// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the multicycle sequencer
// (master) and the memory system (slave).
interface multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: fetch, decode strobes, data access, write-back and
// retire accounting, with a per-request ack timeout that parks the block in ERR.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_halt,
  multicycle_ctrl_if.master bus,
  output logic [31:0]       o_ir_q,
  output logic              o_wrtsrc,
  output logic              o_alusrc,
  output logic [2:0]        o_aluop,
  output logic              o_pc_inc,
  output logic              o_reg_we,
  output logic              o_busy,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_retired
);
  // r_wait holds the number of ack-less cycles already spent in FETCH/MEM.
  localparam int unsigned      WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StErr
  } state_e;

  state_e           r_state;
  logic [31:0]      r_ir;
  logic [WaitW-1:0] r_wait;
  logic [CNT_W-1:0] r_retired;
  logic             r_imem_req;
  logic             r_dmem_req;
  logic             r_dmem_we;
  logic             r_pc_inc;
  logic             r_reg_we;
  logic             r_busy;
  logic             r_err;

  logic [CNT_W-1:0] w_retired_inc;
  logic             w_wait_last;

  assign w_retired_inc = (&r_retired) ? r_retired : r_retired + CNT_W'(1);
  assign w_wait_last   = (r_wait == WaitLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_ir       <= '0;
      r_wait     <= '0;
      r_retired  <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_reg_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_pc_inc <= 1'b0;
      r_reg_we <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state    <= StFetch;
            r_imem_req <= 1'b1;
            r_busy     <= 1'b1;
            r_wait     <= '0;
          end
        end
        StFetch: begin
          if (bus.imem_ack) begin
            r_ir       <= bus.imem_rdata;
            r_imem_req <= 1'b0;
            r_pc_inc   <= 1'b1;
            r_state    <= StDecode;
          end else if (w_wait_last) begin
            r_imem_req <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= StErr;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        StDecode: r_state <= StExec;
        StExec: begin
          if (r_ir[31]) begin
            r_state    <= StMem;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= r_ir[29];
            r_wait     <= '0;
          end else begin
            r_state  <= StWb;
            r_reg_we <= 1'b1;
          end
        end
        StMem: begin
          if (bus.dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (r_dmem_we) begin
              // Stores retire straight out of MEM; no write-back cycle.
              r_retired <= w_retired_inc;
              if (i_halt) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
              end else begin
                r_state    <= StFetch;
                r_imem_req <= 1'b1;
                r_wait     <= '0;
              end
            end else begin
              r_state  <= StWb;
              r_reg_we <= 1'b1;
            end
          end else if (w_wait_last) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= StErr;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        StWb: begin
          r_retired <= w_retired_inc;
          if (i_halt) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= StFetch;
            r_imem_req <= 1'b1;
            r_wait     <= '0;
          end
        end
        StErr:   r_err <= 1'b1;
        default: r_state <= StErr;
      endcase
    end
  end

  assign bus.imem_req = r_imem_req;
  assign bus.dmem_req = r_dmem_req;
  assign bus.dmem_we  = r_dmem_we;

  assign o_ir_q    = r_ir;
  assign o_wrtsrc  = ~r_ir[31];
  assign o_alusrc  = ~r_ir[5];
  assign o_aluop   = {r_ir[5], r_ir[2], r_ir[1] | r_ir[0]};
  assign o_pc_inc  = r_pc_inc;
  assign o_reg_we  = r_reg_we;
  assign o_busy    = r_busy;
  assign o_err     = r_err;
  assign o_retired = r_retired;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction cycle plan yields both stimulus and the
// expected outputs; a CNT_W=2 copy shares the stimulus to exercise counter saturation.
module tb_multicycle_ctrl;
  localparam int unsigned Timeout = 16;
  localparam int unsigned CntW    = 16;
  localparam int          Sat16   = 65535;
  localparam int          Sat2    = 3;

  // ctl bit order: {imem_req, dmem_req, dmem_we, pc_inc, reg_we, busy, err}
  localparam logic [6:0] CtlIdle  = 7'b0000000;
  localparam logic [6:0] CtlFetch = 7'b1000010;
  localparam logic [6:0] CtlDec   = 7'b0001010;
  localparam logic [6:0] CtlExec  = 7'b0000010;
  localparam logic [6:0] CtlWb    = 7'b0000110;
  localparam logic [6:0] CtlErr   = 7'b0000001;

  localparam logic [31:0] InsR1  = 32'h0022_1820;
  localparam logic [31:0] InsLw1 = 32'h8C22_0004;
  localparam logic [31:0] InsSw1 = 32'hAC22_0004;
  localparam logic [31:0] InsR2  = 32'h012A_4024;
  localparam logic [31:0] InsAdi = 32'h2042_0001;
  localparam logic [31:0] InsLw2 = 32'h8C23_0008;

  typedef struct {
    logic        start;
    logic        halt;
    logic        iack;
    logic        dack;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] ir;
    int          ret;
  } exp_t;

  typedef struct {
    logic [6:0] ctl;
    logic [4:0] dec;
    int         ret;
    int         ret2;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic halt  = 1'b0;

  logic [31:0]     ir_q, ir_q2;
  logic            wrtsrc, alusrc, wrtsrc2, alusrc2;
  logic [2:0]      aluop, aluop2;
  logic            pc_inc, reg_we, busy, err;
  logic            pc_inc2, reg_we2, busy2, err2;
  logic [CntW-1:0] retired;
  logic [1:0]      retired2;

  multicycle_ctrl_if u_if ();
  multicycle_ctrl_if u_if2 ();

  assign u_if2.imem_ack   = u_if.imem_ack;
  assign u_if2.imem_rdata = u_if.imem_rdata;
  assign u_if2.dmem_ack   = u_if.dmem_ack;

  multicycle_ctrl #(.TIMEOUT(Timeout), .CNT_W(CntW)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt(halt), .bus(u_if),
    .o_ir_q(ir_q), .o_wrtsrc(wrtsrc), .o_alusrc(alusrc), .o_aluop(aluop),
    .o_pc_inc(pc_inc), .o_reg_we(reg_we), .o_busy(busy), .o_err(err), .o_retired(retired)
  );

  multicycle_ctrl #(.TIMEOUT(Timeout), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt(halt), .bus(u_if2),
    .o_ir_q(ir_q2), .o_wrtsrc(wrtsrc2), .o_alusrc(alusrc2), .o_aluop(aluop2),
    .o_pc_inc(pc_inc2), .o_reg_we(reg_we2), .o_busy(busy2), .o_err(err2), .o_retired(retired2)
  );

  always #5 clk = ~clk;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  obs_t        obs[0:4095];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          m_ret = 0;
  logic [31:0] m_ir = '0;

  function automatic void push(input logic st, input logic hl, input logic ia, input logic da,
                               input logic [31:0] rd, input logic [6:0] ctl);
    stim_t s;
    exp_t  e;
    s.start = st; s.halt = hl; s.iack = ia; s.dack = da; s.rdata = rd;
    e.ctl = ctl; e.ir = m_ir; e.ret = m_ret;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  // Idle cycles; halt and both acks are held high to show they are ignored.
  function automatic void add_idle(input int n, input logic go);
    for (int i = 0; i < n; i++) push(go && (i == n - 1), 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, CtlIdle);
  endfunction

  // One instruction: fetch waits fwait cycles for ack, MEM waits mwait cycles.
  // cut_mem >= 0 stops the plan after that many ack-less MEM cycles.
  function automatic void add_instr(input logic [31:0] ins, input int fwait, input int mwait,
                                    input logic hlt, input int cut_mem);
    logic is_store;
    int   n;
    is_store = ins[31] & ins[29];
    for (int i = 0; i <= fwait; i++)
      push(1'b0, 1'b0, i == fwait, 1'b1, (i == fwait) ? ins : ~ins, CtlFetch);
    m_ir = ins;
    push(1'b0, hlt, 1'b1, 1'b1, ~ins, CtlDec);
    push(1'b0, hlt, 1'b1, 1'b1, ~ins, CtlExec);
    if (ins[31]) begin
      n = (cut_mem >= 0) ? cut_mem : mwait + 1;
      for (int i = 0; i < n; i++)
        push(1'b0, hlt, 1'b1, (cut_mem < 0) && (i == mwait), ~ins, {2'b01, ins[29], 4'b0010});
      if (cut_mem >= 0) return;
    end
    if (!is_store) push(1'b0, hlt, 1'b1, 1'b0, ~ins, CtlWb);
    m_ret++;
  endfunction

  function automatic void add_fetch_timeout(input int nerr);
    for (int i = 0; i < int'(Timeout); i++) push(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, CtlFetch);
    for (int i = 0; i < nerr; i++) push(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, CtlErr);
  endfunction

  function automatic int plan_pos();
    return cyc + exp_q.size();
  endfunction

  task automatic check_cycle(input exp_t e);
    logic [6:0] act, act2;
    logic [4:0] dec_a, dec_e;
    int         r_e16, r_e2;
    act   = {u_if.imem_req, u_if.dmem_req, u_if.dmem_we & e.ctl[5], pc_inc, reg_we, busy, err};
    act2  = {u_if2.imem_req, u_if2.dmem_req, u_if2.dmem_we & e.ctl[5], pc_inc2, reg_we2, busy2,
             err2};
    dec_a = {wrtsrc, alusrc, aluop};
    dec_e = {~e.ir[31], ~e.ir[5], e.ir[5], e.ir[2], e.ir[1] | e.ir[0]};
    r_e16 = (e.ret > Sat16) ? Sat16 : e.ret;
    r_e2  = (e.ret > Sat2) ? Sat2 : e.ret;
    if (cyc < 4096) begin
      obs[cyc].ctl  = act;
      obs[cyc].dec  = dec_a;
      obs[cyc].ret  = int'(retired);
      obs[cyc].ret2 = int'(retired2);
    end
    checks++;
    if (act !== e.ctl || act2 !== e.ctl || ir_q !== e.ir || ir_q2 !== e.ir || dec_a !== dec_e ||
        retired !== CntW'(r_e16) || retired2 !== 2'(r_e2)) begin
      failures++;
      $display("FAIL cycle%0d ctl act=%b/%b req=%b ir act=%h/%h req=%h dec act=%b req=%b retired act=%0d/%0d req=%0d/%0d",
               cyc, act, act2, e.ctl, ir_q, ir_q2, e.ir, dec_a, dec_e, retired, retired2, r_e16,
               r_e2);
    end
    cyc++;
  endtask

  task automatic run_plan();
    stim_t s;
    exp_t  e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      check_cycle(e);
      start           = s.start;
      halt            = s.halt;
      u_if.imem_ack   = s.iack;
      u_if.dmem_ack   = s.dack;
      u_if.imem_rdata = s.rdata;
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic reset_lits(input string tag);
    lit({tag, "_reqs"}, 32'({u_if.imem_req, u_if.dmem_req, u_if2.imem_req, u_if2.dmem_req}), 0);
    lit({tag, "_strobes"}, 32'({pc_inc, reg_we, pc_inc2, reg_we2}), 0);
    lit({tag, "_busy_err"}, 32'({busy, err, busy2, err2}), 0);
    lit({tag, "_retired"}, 32'(retired), 0);
    lit({tag, "_retired_w2"}, 32'(retired2), 0);
    lit({tag, "_ir"}, ir_q, 0);
    lit({tag, "_decode"}, 32'({wrtsrc, alusrc, aluop}), 32'h18);
  endtask

  // Drops rst_n between clock edges so only an asynchronous reset clears state in time.
  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 reset_lits(tag);
    start = 1'b0; halt = 1'b0;
    u_if.imem_ack = 1'b0; u_if.dmem_ack = 1'b0; u_if.imem_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ret = 0;
    m_ir  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m1, m2, m3, m5, m6, m7, mt, m8;
    logic any_we;
    u_if.imem_ack = 1'b0; u_if.dmem_ack = 1'b0; u_if.imem_rdata = '0;

    apply_reset("rst0");
    add_idle(1, 1'b0);
    m1 = plan_pos();
    add_idle(1, 1'b1);
    add_instr(InsR1, 0, 0, 1'b0, -1);
    m2 = plan_pos() - 1;
    add_instr(InsLw1, 0, 3, 1'b0, -1);
    m3 = plan_pos() - 1;
    add_instr(InsSw1, 0, 0, 1'b1, -1);
    add_idle(3, 1'b1);
    m5 = plan_pos() - 1;
    add_instr(InsR2, 2, 0, 1'b1, -1);
    add_idle(2, 1'b1);
    m6 = plan_pos() - 1;
    add_instr(InsAdi, int'(Timeout) - 1, 0, 1'b0, -1);
    m7 = plan_pos() - 1;
    add_instr(InsLw2, 0, int'(Timeout) - 1, 1'b0, -1);
    mt = plan_pos() - 1;
    add_fetch_timeout(4);
    run_plan();

    lit("r_pcinc_c1", 32'(obs[m1 + 1].ctl[3]), 0);
    lit("r_pcinc_c2", 32'(obs[m1 + 2].ctl[3]), 1);
    lit("r_regwe_c4", 32'(obs[m1 + 4].ctl[2]), 1);
    lit("r_decode", 32'(obs[m1 + 4].dec), 32'b10100);
    lit("r_imemreq_c5", 32'(obs[m1 + 5].ctl[6]), 1);
    lit("r_retired_c5", 32'(obs[m1 + 5].ret), 1);
    lit("lw_dmem_req_we", 32'(obs[m2 + 4].ctl[5:4]), 32'b10);
    lit("lw_req_4th", 32'(obs[m2 + 7].ctl[5]), 1);
    lit("lw_regwe_c8", 32'(obs[m2 + 8].ctl[2]), 1);
    lit("lw_wrtsrc", 32'(obs[m2 + 8].dec[4]), 0);
    lit("lw_retired", 32'(obs[m2 + 9].ret), 2);
    lit("sw_dmem_req_we", 32'(obs[m3 + 4].ctl[5:4]), 32'b11);
    any_we = 1'b0;
    for (int k = 1; k <= 5; k++) any_we = any_we | obs[m3 + k].ctl[2];
    lit("sw_no_regwe", 32'(any_we), 0);
    lit("sw_retired", 32'(obs[m3 + 5].ret), 3);
    lit("sw_halt_idle", 32'(obs[m3 + 5].ctl), 0);
    lit("halt_regwe", 32'(obs[m5 + 6].ctl[2]), 1);
    lit("halt_decode", 32'(obs[m5 + 6].dec), 32'b10110);
    lit("halt_idle", 32'(obs[m5 + 7].ctl), 0);
    lit("halt_retired", 32'(obs[m5 + 7].ret), 4);
    lit("resume_fetch", 32'(obs[m5 + 9].ctl[6]), 1);
    lit("fetch_ack_16th", 32'(obs[m6 + 17].ctl[3]), 1);
    lit("addi_decode", 32'(obs[m6 + 19].dec), 32'b11001);
    lit("sat_w2_5", 32'(obs[m6 + 20].ret2), 3);
    lit("mem_ack_16th", 32'(obs[m7 + 20].ctl[2]), 1);
    lit("to_req_16", 32'(obs[mt + 16].ctl[6]), 1);
    lit("to_err", 32'(obs[mt + 17].ctl), 32'b0000001);
    lit("to_err_held", 32'(obs[mt + 20].ctl), 32'b0000001);
    lit("to_retired", 32'(obs[mt + 20].ret), 6);

    apply_reset("rst_err");
    add_idle(1, 1'b1);
    add_instr(InsR1, 0, 0, 1'b0, -1);
    m8 = plan_pos() - 1;
    add_instr(InsLw1, 0, 0, 1'b0, 2);
    run_plan();
    lit("mid_mem_req", 32'(obs[m8 + 5].ctl[5]), 1);
    lit("mid_mem_retired", 32'(obs[m8 + 5].ret), 1);
    apply_reset("rst_mem");
    add_idle(3, 1'b0);
    run_plan();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
